// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Four-digit multiplexed 7-segment scanner with per-slot blanking
//               and frame-synchronous (tear-free) value updates.
//               Optional leading-zero blanking: define DISPLAY_SCANNER_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  nibble,
    output logic [3:0]  dig_n,
    output logic        dp_n,
    output logic        pend,
    output logic        frame
);

    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] C_BLANK   = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_disp;
    logic [3:0]       r_dpd;
    logic [15:0]      r_pend_val;
    logic [3:0]       r_pend_dp;
    logic             r_pend;

    logic             w_slot_end;
    logic             w_frame;
    logic             w_lead_zero;
    logic             w_lit;

    assign w_slot_end = (r_cnt == C_CNT_MAX);
    assign w_frame    = w_slot_end && (r_idx == 2'd3);

    // Slot timing: cnt runs through one digit slot, idx steps at slot end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Loads are parked until the frame boundary so all four digits change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= 16'h0000;
            r_dpd      <= 4'h0;
            r_pend_val <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_pend     <= 1'b0;
        end else if (load && w_frame) begin
            r_disp <= value_in;
            r_dpd  <= dp_in;
            r_pend <= 1'b0;
        end else if (load) begin
            r_pend_val <= value_in;
            r_pend_dp  <= dp_in;
            r_pend     <= 1'b1;
        end else if (w_frame && r_pend) begin
            r_disp <= r_pend_val;
            r_dpd  <= r_pend_dp;
            r_pend <= 1'b0;
        end
    end

`ifdef DISPLAY_SCANNER_LZB_EN
    // A digit is a leading zero when it and every more significant digit are
    // zero and no decimal point is requested on it; digit 0 is never blanked.
    always_comb begin
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd1:    w_lead_zero = (r_disp[15:4]  == 12'h000) && !r_dpd[1];
            2'd2:    w_lead_zero = (r_disp[15:8]  == 8'h00)   && !r_dpd[2];
            2'd3:    w_lead_zero = (r_disp[15:12] == 4'h0)    && !r_dpd[3];
            default: w_lead_zero = 1'b0;
        endcase
    end
`else
    assign w_lead_zero = 1'b0;
`endif

    // rst_n gating keeps the digits dark during reset even when BLANK_CYC is 0.
    assign w_lit  = rst_n && (r_cnt >= C_BLANK) && !w_lead_zero;

    assign dig_n  = w_lit ? ~(4'b0001 << r_idx) : 4'hF;
    assign dp_n   = ~(w_lit & r_dpd[r_idx]);
    assign nibble = r_disp[{r_idx, 2'b00} +: 4];
    assign pend   = r_pend;
    assign frame  = w_frame;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scanner
// Description : Self-checking bench for display_scanner (REFRESH_DIV=8, BLANK_CYC=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int FLEN  = 4 * RDIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  nibble;
    logic [3:0]  dig_n;
    logic        dp_n;
    logic        pend;
    logic        frame;

    int total;
    int bad;
    int pos;

    display_scanner #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .nibble   (nibble),
        .dig_n    (dig_n),
        .dp_n     (dp_n),
        .pend     (pend),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] dig_n;
        logic       frame;
    } vec_t;

    vec_t tbl [FLEN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, pos);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        pos = (pos + 1) % FLEN;
    endtask

    task automatic goto(input int p);
        while (pos != p) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load     = 1'b1;
        value_in = v;
        dp_in    = d;
        step();
        load     = 1'b0;
    endtask

    function automatic logic [3:0] sel(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << k);
    endfunction

    // Checks the middle of each slot of the frame starting at pos 0.
    task automatic check_frame(input string name, input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            goto(k * RDIV + 4);
            chk({name, "_dig"}, 32'(dig_n), 32'(sel(k)));
            chk({name, "_nib"}, 32'(nibble), 32'(v[4*k +: 4]));
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        pos      = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0;
        dp_in    = 4'h0;

        // Expected scan pattern after reset: 2 dark cycles then the digit select.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < RDIV; c++) begin
                tbl[k*RDIV + c].dig_n = (c < BLANK) ? 4'hF : sel(k);
                tbl[k*RDIV + c].frame = (k == 3 && c == RDIV - 1);
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("rst_dig", 32'(dig_n), 32'hF);
        chk("rst_dp", 32'(dp_n), 32'h1);
        chk("rst_nib", 32'(nibble), 32'h0);
        chk("rst_frame", 32'(frame), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        rst_n = 1'b1;
        pos   = 0;

        for (int i = 0; i < FLEN; i++) begin
            chk("scan_dig", 32'(dig_n), 32'(tbl[i].dig_n));
            chk("scan_frame", 32'(frame), 32'(tbl[i].frame));
            chk("scan_dp", 32'(dp_n), 32'h1);
            step();
        end

        // Load in slot 1, held pending until the frame boundary.
        goto(RDIV + 3);
        do_load(16'h1A3C, 4'h0);
        chk("p1_pend", 32'(pend), 32'h1);
        goto(3 * RDIV + 4);
        chk("p1_notear", 32'(nibble), 32'h0);
        goto(FLEN - 1);
        chk("p1_frame", 32'(frame), 32'h1);
        chk("p1_pend_hold", 32'(pend), 32'h1);
        step();
        chk("p1_pend_clr", 32'(pend), 32'h0);
        check_frame("p1", 16'h1A3C);

        // Two loads in one frame: the last one wins.
        step();
        goto(2);
        do_load(16'h1111, 4'h0);
        goto(RDIV + 2);
        do_load(16'h2222, 4'h0);
        goto(2 * RDIV + 4);
        chk("p2_old", 32'(nibble), 32'hA);
        goto(FLEN - 1);
        step();
        check_frame("p2", 16'h2222);

        // Load coinciding with frame goes straight to the display.
        goto(FLEN - 1);
        chk("p3_frame", 32'(frame), 32'h1);
        load     = 1'b1;
        value_in = 16'h00F0;
        dp_in    = 4'h0;
        step();
        load     = 1'b0;
        chk("p3_pend", 32'(pend), 32'h0);
        check_frame("p3", 16'h00F0);
        chk("p3_pend_end", 32'(pend), 32'h0);

        // Decimal point on digit 1 only, and dark during blanking.
        goto(5);
        do_load(16'h1234, 4'b0010);
        goto(FLEN - 1);
        step();
        goto(4);
        chk("dp_d0", 32'(dp_n), 32'h1);
        goto(RDIV);
        chk("dp_blank_dig", 32'(dig_n), 32'hF);
        chk("dp_blank", 32'(dp_n), 32'h1);
        goto(RDIV + 4);
        chk("dp_d1", 32'(dp_n), 32'h0);
        chk("dp_d1_nib", 32'(nibble), 32'h3);

        // Leading-zero handling.
        goto(FLEN - 2);
        do_load(16'h0005, 4'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            goto(k * RDIV + 4);
`ifdef DISPLAY_SCANNER_LZB_EN
            chk("lz_dig", 32'(dig_n), (k == 0) ? 32'(sel(0)) : 32'hF);
            chk("lz_dp", 32'(dp_n), 32'h1);
`else
            chk("lz_dig", 32'(dig_n), 32'(sel(k)));
`endif
            chk("lz_nib", 32'(nibble), (k == 0) ? 32'h5 : 32'h0);
        end
        goto(FLEN - 2);
        do_load(16'h0005, 4'b0100);
        step();
        goto(2 * RDIV + 4);
        chk("lz_d2_dig", 32'(dig_n), 32'(sel(2)));
        chk("lz_d2_nib", 32'(nibble), 32'h0);
        chk("lz_d2_dp", 32'(dp_n), 32'h0);
        goto(3 * RDIV + 4);
`ifdef DISPLAY_SCANNER_LZB_EN
        chk("lz_d3_dig", 32'(dig_n), 32'hF);
`else
        chk("lz_d3_dig", 32'(dig_n), 32'(sel(3)));
`endif

        // Reset mid slot 2 with a pending value.
        goto(RDIV * 2 + 1);
        do_load(16'h9999, 4'hF);
        chk("r_pend_set", 32'(pend), 32'h1);
        goto(RDIV * 2 + 4);
        rst_n = 1'b0;
        #1;
        chk("r_dig_now", 32'(dig_n), 32'hF);
        chk("r_pend_now", 32'(pend), 32'h0);
        chk("r_dp_now", 32'(dp_n), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        pos   = 0;
        chk("r_cnt0_dig", 32'(dig_n), 32'hF);
        goto(4);
        chk("r_dig0", 32'(dig_n), 32'(sel(0)));
        chk("r_nib0", 32'(nibble), 32'h0);
        chk("r_dp0", 32'(dp_n), 32'h1);
        goto(FLEN - 1);
        chk("r_pend_frame", 32'(pend), 32'h0);
        step();
        goto(RDIV + 4);
        chk("r_nib1", 32'(nibble), 32'h0);
        chk("r_dp1", 32'(dp_n), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
